psg_bus_ctrl: RTL and testbench
===============================

# psg_bus_ctrl

Bus sequencer and arbiter in front of the PSG register port. It turns CPU port writes and writes from a register-loader engine (snapshot restore, power-on preset) into correctly phased bdir/bc1/d cycles, qualified by the PSG clock enable. After every loader access it restores the CPU-visible register address, so CPU data writes and reads always target the register the CPU last selected.

## Interface
- No parameters. Register-address mask constant is fixed at 4'b0000 in the shared package.
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low.
- ce  in  1  PSG clock enable; the PSG samples bdir/bc1/d only on posedges with ce=1.
- cpu_aw  in  1  one-cycle pulse: CPU address-latch write, data on cpu_d.
- cpu_dw  in  1  one-cycle pulse: CPU data write, data on cpu_d.
- cpu_d  in  8  CPU write data; sampled with cpu_aw/cpu_dw.
- cpu_busy  out  1  CPU request buffer occupied.
- cpu_rd_ok  out  1  PSG address equals shadow and no op in flight; CPU reads of PSG q are valid.
- cpu_ovr  out  1  sticky: CPU pulse arrived while cpu_busy=1. Cleared only by reset.
- ld_req  in  1  loader request level; hold until ld_ack.
- ld_addr  in  4  loader target register.
- ld_data  in  8  loader data.
- ld_ack  out  1  one-cycle pulse: loader data phase committed.
- psg_bdir  out  1  to PSG bdir.
- psg_bc1  out  1  to PSG bc1.
- psg_d  out  8  to PSG d.

## Operation
- CPU buffer: one entry {kind, data}.
  - Filled on cpu_aw/cpu_dw when empty.
  - A pulse while full is dropped and sets cpu_ovr.
  - cpu_aw and cpu_dw in the same cycle: cpu_aw wins, cpu_dw is dropped, cpu_ovr is set.
- Shadow address (4 bits) is updated when a CPU ADDR phase commits and cpu data[7:4]==0. A nonzero upper nibble is issued to the PSG unchanged, and the PSG ignores it; the shadow stays unchanged.
- FSM states: IDLE, ADDR, DATA, RESTORE.
  - IDLE: CPU buffer full goes to ADDR (kind=addr) or DATA (kind=data). Else ld_req goes to ADDR with loader source. CPU has priority.
  - ADDR: drive bdir=1, bc1=1, d={4'b0, addr}. For a CPU source, d=cpu data verbatim.
  - DATA: drive bdir=1, bc1=0, d=data.
  - RESTORE: drive bdir=1, bc1=1, d={4'b0, shadow}.
  - In IDLE, drive bdir=0, bc1=0, d=0.
- A phase commits on the first posedge where ce=1 while in it. The state advances on that same edge.
- Transitions on commit:
  - CPU ADDR → IDLE, clear buffer.
  - CPU DATA → IDLE, clear buffer.
  - Loader ADDR → DATA.
  - Loader DATA → RESTORE, with ld_ack pulsed in the following cycle.
  - RESTORE → IDLE.
- A CPU request arriving during a loader sequence waits in the buffer until the next IDLE; it never preempts mid-sequence.
- Loader writes to register 13 retrigger the PSG envelope exactly like CPU writes. No filtering.
- cpu_rd_ok = (state==IDLE) & !cpu_busy.

## Timing
- Reset values: state IDLE, psg_bdir=0, psg_bc1=0, psg_d=0, ld_ack=0, cpu_busy=0, cpu_rd_ok=1, cpu_ovr=0, shadow=0. This matches the PSG address reset of 0.
- All outputs are registered. psg_* change only on posedge clock.
- A phase is held stable for at least one full ce period, so the PSG sees a constant bdir/bc1/d across its sampling edge.
- CPU op latency with ce always 1:
  - Pulse at edge N.
  - Buffer full after N.
  - Phase driven after N+1, committed at N+2.
  - cpu_busy=0 after N+2.
- Loader sequence with ce always 1: 3 committed phases. ld_ack is high for exactly one cycle after the DATA commit. The loader must drop or change ld_req on the ack cycle; ld_req still high in IDLE starts a new sequence.
- If ce=0, all phases stretch indefinitely; no timeout.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight loader write is lost and no ld_ack is issued.

## Structure
- Shared package psg_pkg holds:
  - the state enum {IDLE, ADDR, DATA, RESTORE};
  - bus code constants BUS_IDLE=2'b00, BUS_WR=2'b10, BUS_ADDR=2'b11 for {bdir, bc1};
  - ADDRMASK=4'b0000.
- Sub-module psg_cpu_buf: the one-entry CPU buffer plus overrun flag.
- The FSM and mux live in the top level.

## Test plan
- ce=1, cpu_aw d=8'h07 then cpu_dw d=8'h38 → ADDR phase d=07 then DATA phase d=38; shadow=7; cpu_busy clears 2 cycles after each pulse.
- ce pulses every 8 clocks, single cpu_dw d=8'h55 → bdir=1, bc1=0 held a full 8 cycles; commit on the ce edge; cpu_busy low afterwards.
- Shadow=8, ld_req addr=13 data=8'h0E → phases ADDR d=0D, DATA d=0E, RESTORE d=08; one ld_ack pulse; cpu_rd_ok low throughout, then 1.
- ld_req in progress and cpu_dw d=8'hAA during DATA → the CPU op starts only after RESTORE commits, with d=AA and the shadow address intact.
- Two cpu_dw pulses in back-to-back cycles → first executes, second dropped, cpu_ovr=1 until reset.
- Reset asserted during loader DATA phase → psg_bdir=0, psg_bc1=0, psg_d=0 immediately; ld_ack never pulses; shadow=0.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared types and constants for the PSG bus controller.
// Bus codes are {bdir, bc1}.
package psg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StRestore
    } state_e;

    typedef enum logic {
        SrcCpu,
        SrcLd
    } src_e;

    typedef enum logic {
        KindAddr,
        KindData
    } kind_e;

    localparam logic [1:0] BusIdle = 2'b00;
    localparam logic [1:0] BusWr   = 2'b10;
    localparam logic [1:0] BusAddr = 2'b11;

    // Upper nibble that a CPU address write must carry to select a register.
    localparam logic [3:0] AddrMask = 4'b0000;

endpackage

// File: rtl/psg_cpu_buf.sv
// One-entry CPU request buffer with a sticky overrun flag.
// A pulse that cannot be accepted sets the overrun flag.
module psg_cpu_buf
    import psg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_aw_i,
    input  logic       cpu_dw_i,
    input  logic [7:0] cpu_d_i,
    input  logic       clr_i,
    output logic       valid_o,
    output logic       kind_o,
    output logic [7:0] data_o,
    output logic       ovr_o
);

    logic       valid_q, valid_d;
    kind_e      kind_q, kind_d;
    logic [7:0] data_q, data_d;
    logic       ovr_q, ovr_d;

    always_comb begin
        valid_d = valid_q;
        kind_d  = kind_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end
        // A pulse landing on the clear edge still sees an occupied buffer.
        if (valid_q) begin
            if (cpu_aw_i || cpu_dw_i) begin
                ovr_d = 1'b1;
            end
        end else if (cpu_aw_i) begin
            valid_d = 1'b1;
            kind_d  = KindAddr;
            data_d  = cpu_d_i;
            if (cpu_dw_i) begin
                ovr_d = 1'b1;
            end
        end else if (cpu_dw_i) begin
            valid_d = 1'b1;
            kind_d  = KindData;
            data_d  = cpu_d_i;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            kind_q  <= KindAddr;
            data_q  <= 8'h00;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            kind_q  <= kind_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign valid_o = valid_q;
    assign kind_o  = kind_q;
    assign data_o  = data_q;
    assign ovr_o   = ovr_q;

endmodule

// File: rtl/psg_bus_ctrl.sv
// Sequences CPU and loader accesses onto the PSG bdir/bc1/d port, qualified by ce.
// Loader writes are followed by a RESTORE of the CPU-selected register address.
module psg_bus_ctrl
    import psg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ce_i,
    input  logic       cpu_aw_i,
    input  logic       cpu_dw_i,
    input  logic [7:0] cpu_d_i,
    output logic       cpu_busy_o,
    output logic       cpu_rd_ok_o,
    output logic       cpu_ovr_o,
    input  logic       ld_req_i,
    input  logic [3:0] ld_addr_i,
    input  logic [7:0] ld_data_i,
    output logic       ld_ack_o,
    output logic       psg_bdir_o,
    output logic       psg_bc1_o,
    output logic [7:0] psg_d_o
);

    state_e     state_q, state_d;
    src_e       src_q, src_d;
    logic [3:0] ld_addr_q, ld_addr_d;
    logic [7:0] ld_data_q, ld_data_d;
    logic [3:0] shadow_q, shadow_d;
    logic       ack_q, ack_d;
    logic [1:0] bus_q, bus_d;
    logic [7:0] d_q, d_d;

    logic       buf_valid;
    logic       buf_kind;
    logic [7:0] buf_data;
    logic       buf_clr;

    psg_cpu_buf u_cpu_buf (
        .clock   (clock),
        .reset   (reset),
        .cpu_aw_i(cpu_aw_i),
        .cpu_dw_i(cpu_dw_i),
        .cpu_d_i (cpu_d_i),
        .clr_i   (buf_clr),
        .valid_o (buf_valid),
        .kind_o  (buf_kind),
        .data_o  (buf_data),
        .ovr_o   (cpu_ovr_o)
    );

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        shadow_d  = shadow_q;
        ack_d     = 1'b0;
        buf_clr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (buf_valid) begin
                    src_d   = SrcCpu;
                    state_d = (buf_kind == KindData) ? StData : StAddr;
                end else if (ld_req_i) begin
                    src_d     = SrcLd;
                    ld_addr_d = ld_addr_i;
                    ld_data_d = ld_data_i;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                if (ce_i) begin
                    if (src_q == SrcCpu) begin
                        buf_clr = 1'b1;
                        state_d = StIdle;
                        if (buf_data[7:4] == AddrMask) begin
                            shadow_d = buf_data[3:0];
                        end
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (ce_i) begin
                    if (src_q == SrcCpu) begin
                        buf_clr = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = StRestore;
                    end
                end
            end
            StRestore: begin
                if (ce_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs are decoded from the next state so they are registered with it.
    always_comb begin
        bus_d = BusIdle;
        d_d   = 8'h00;
        unique case (state_d)
            StIdle: begin
                bus_d = BusIdle;
                d_d   = 8'h00;
            end
            StAddr: begin
                bus_d = BusAddr;
                d_d   = (src_d == SrcCpu) ? buf_data : {4'b0000, ld_addr_d};
            end
            StData: begin
                bus_d = BusWr;
                d_d   = (src_d == SrcCpu) ? buf_data : ld_data_d;
            end
            StRestore: begin
                bus_d = BusAddr;
                d_d   = {4'b0000, shadow_d};
            end
            default: begin
                bus_d = BusIdle;
                d_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            src_q     <= SrcCpu;
            ld_addr_q <= 4'h0;
            ld_data_q <= 8'h00;
            shadow_q  <= 4'h0;
            ack_q     <= 1'b0;
            bus_q     <= BusIdle;
            d_q       <= 8'h00;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            ld_addr_q <= ld_addr_d;
            ld_data_q <= ld_data_d;
            shadow_q  <= shadow_d;
            ack_q     <= ack_d;
            bus_q     <= bus_d;
            d_q       <= d_d;
        end
    end

    assign psg_bdir_o  = bus_q[1];
    assign psg_bc1_o   = bus_q[0];
    assign psg_d_o     = d_q;
    assign ld_ack_o    = ack_q;
    assign cpu_busy_o  = buf_valid;
    assign cpu_rd_ok_o = (state_q == StIdle) && !buf_valid;

endmodule

// File: tb/tb_psg_bus_ctrl.sv
// Directed, table-driven bench for psg_bus_ctrl; one row per clock cycle,
// outputs checked 1 time unit after the rising edge.
module tb_psg_bus_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce = 1'b1;
    logic       cpu_aw = 1'b0;
    logic       cpu_dw = 1'b0;
    logic [7:0] cpu_d = 8'h00;
    logic       cpu_busy, cpu_rd_ok, cpu_ovr;
    logic       ld_req = 1'b0;
    logic [3:0] ld_addr = 4'h0;
    logic [7:0] ld_data = 8'h00;
    logic       ld_ack;
    logic       psg_bdir, psg_bc1;
    logic [7:0] psg_d;

    int n_vec = 0;
    int n_err = 0;

    psg_bus_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .ce_i       (ce),
        .cpu_aw_i   (cpu_aw),
        .cpu_dw_i   (cpu_dw),
        .cpu_d_i    (cpu_d),
        .cpu_busy_o (cpu_busy),
        .cpu_rd_ok_o(cpu_rd_ok),
        .cpu_ovr_o  (cpu_ovr),
        .ld_req_i   (ld_req),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .ld_ack_o   (ld_ack),
        .psg_bdir_o (psg_bdir),
        .psg_bc1_o  (psg_bc1),
        .psg_d_o    (psg_d)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       ce;
        logic       aw;
        logic       dw;
        logic [7:0] d;
        logic       lr;
        logic [3:0] la;
        logic [7:0] ld;
        logic [13:0] exp;  // {bdir, bc1, d[7:0], busy, rd_ok, ack, ovr}
    } vec_t;

    vec_t vecs[$];

    function automatic logic [13:0] ex(logic bdir, logic bc1, logic [7:0] d, logic busy,
                                       logic rdok, logic ack, logic ovr);
        return {bdir, bc1, d, busy, rdok, ack, ovr};
    endfunction

    function automatic vec_t mk(logic c, logic aw, logic dw, logic [7:0] d, logic lr,
                                logic [3:0] la, logic [7:0] ld, logic [13:0] e);
        vec_t v;
        v.ce = c; v.aw = aw; v.dw = dw; v.d = d;
        v.lr = lr; v.la = la; v.ld = ld; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [13:0] e);
        logic [13:0] got;
        got = {psg_bdir, psg_bc1, psg_d, cpu_busy, cpu_rd_ok, ld_ack, cpu_ovr};
        n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got bdir=%b bc1=%b d=%h busy=%b rd_ok=%b ack=%b ovr=%b, want bdir=%b bc1=%b d=%h busy=%b rd_ok=%b ack=%b ovr=%b",
                     name, got[13], got[12], got[11:4], got[3], got[2], got[1], got[0],
                     e[13], e[12], e[11:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic run(input string name, input vec_t v);
        @(negedge clock);
        ce = v.ce; cpu_aw = v.aw; cpu_dw = v.dw; cpu_d = v.d;
        ld_req = v.lr; ld_addr = v.la; ld_data = v.ld;
        @(posedge clock);
        #1;
        chk(name, v.exp);
    endtask

    initial begin
        // CPU address 07 then data 38, ce always high
        vecs.push_back(mk(1, 1, 0, 8'h07, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(1, 1, 8'h07, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        vecs.push_back(mk(1, 0, 1, 8'h38, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(1, 0, 8'h38, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        // Nonzero upper nibble passes through verbatim, shadow stays 7
        vecs.push_back(mk(1, 1, 0, 8'h1F, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(1, 1, 8'h1F, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        // Loader reg 13 <= 0E, restore to 07
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'hD, 8'h0E, ex(1, 1, 8'h0D, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'hD, 8'h0E, ex(1, 0, 8'h0E, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'hD, 8'h0E, ex(1, 1, 8'h07, 0, 0, 1, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        // Shadow 8, then CPU write AA arrives during loader DATA and waits
        vecs.push_back(mk(1, 1, 0, 8'h08, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(1, 1, 8'h08, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'hD, 8'h0E, ex(1, 1, 8'h0D, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 1, 8'hAA, 1, 4'hD, 8'h0E, ex(1, 0, 8'h0E, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'hD, 8'h0E, ex(1, 1, 8'h08, 1, 0, 1, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(1, 0, 8'hAA, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        // Shadow still 8 after the CPU data write
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'h2, 8'h33, ex(1, 1, 8'h02, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'h2, 8'h33, ex(1, 0, 8'h33, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 4'h2, 8'h33, ex(1, 1, 8'h08, 0, 0, 1, 0)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        // Back-to-back data writes: second dropped, overrun sticks
        vecs.push_back(mk(1, 0, 1, 8'h11, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 1, 8'h22, 0, 4'h0, 8'h00, ex(1, 0, 8'h11, 1, 0, 0, 1)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 1)));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 1)));

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", ex(0, 0, 8'h00, 0, 1, 0, 0));
        @(negedge clock);
        reset = 1'b1;

        // Slow ce: data phase 55 holds while ce is low, commits on the ce edge
        run("slow_pulse", mk(0, 0, 1, 8'h55, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 0)));
        for (int i = 0; i < 8; i++) begin
            run($sformatf("slow_hold%0d", i),
                mk(0, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(1, 0, 8'h55, 1, 0, 0, 0)));
        end
        run("slow_commit", mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));

        foreach (vecs[i]) begin
            run($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during loader DATA phase
        run("rst_ld_addr", mk(1, 0, 0, 8'h00, 1, 4'h5, 8'h99, ex(1, 1, 8'h05, 0, 0, 0, 1)));
        run("rst_ld_data", mk(1, 0, 0, 8'h00, 1, 4'h5, 8'h99, ex(1, 0, 8'h99, 0, 0, 0, 1)));
        @(negedge clock);
        reset = 1'b0;
        ld_req = 1'b0;
        #1;
        chk("rst_immediate", ex(0, 0, 8'h00, 0, 1, 0, 0));
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run($sformatf("rst_no_ack%0d", i),
                mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        end
        // Shadow back to 0
        run("post_rst_a", mk(1, 0, 0, 8'h00, 1, 4'h1, 8'h02, ex(1, 1, 8'h01, 0, 0, 0, 0)));
        run("post_rst_d", mk(1, 0, 0, 8'h00, 1, 4'h1, 8'h02, ex(1, 0, 8'h02, 0, 0, 0, 0)));
        run("post_rst_r", mk(1, 0, 0, 8'h00, 1, 4'h1, 8'h02, ex(1, 1, 8'h00, 0, 0, 1, 0)));
        run("post_rst_i", mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 0)));
        // Simultaneous aw/dw: address wins, overrun set
        run("awdw_pulse", mk(1, 1, 1, 8'h03, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 1, 0, 0, 1)));
        run("awdw_addr", mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(1, 1, 8'h03, 1, 0, 0, 1)));
        run("awdw_idle", mk(1, 0, 0, 8'h00, 0, 4'h0, 8'h00, ex(0, 0, 8'h00, 0, 1, 0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
